// File: rtl/spi_trig_pkg.sv
// Shared types and helpers for the SPI receive-side trigger.
// Helpers work at 64-bit width; callers truncate to their DATA_W.
package spi_trig_pkg;

    typedef enum logic {IDLE, RX} state_t;

    localparam int MAX_W = 64;

    function automatic logic [6:0] eff_len(
        input logic [6:0] len,
        input logic [6:0] dw
    );
        return (len == 7'd0 || len > dw) ? dw : len;
    endfunction

    function automatic logic [MAX_W-1:0] len_mask(
        input logic [6:0] el
    );
        logic [MAX_W-1:0] m;
        if (el >= 7'd64) m = '1;
        else m = (64'd1 << el) - 64'd1;
        return m;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// N-flop synchroniser plus one history flop.
// Gives the synced level, the delayed level and rise/fall pulses.
module sync_edge_det #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic q_d,
    output logic rise,
    output logic fall
);

    logic [DEPTH:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= {(DEPTH+1){RST_VAL}};
        else        ff <= {ff[DEPTH-1:0], d};
    end

    assign q    = ff[DEPTH-1];
    assign q_d  = ff[DEPTH];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/spi_rx_trig_gen.sv
// SPI receive-side trigger: snoops SS_n/SCLK/MOSI, assembles words
// of programmable length and pulses on a qualifying masked match.
module spi_rx_trig_gen
    import spi_trig_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = $clog2(DATA_W+1),
    parameter int WCNT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              SCLK,
    input  logic              MOSI,
    input  logic              edg,
    input  logic [LEN_W-1:0]  len,
    input  logic              lsb_first,
    input  logic [WCNT_W-1:0] word_sel,
    input  logic [DATA_W-1:0] mask,
    input  logic [DATA_W-1:0] match,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_vld,
    output logic              SPItrig,
    output logic              frame_err
);

    localparam logic [6:0] DW7 = 7'(DATA_W);

    logic sclk_rise, sclk_fall, sclk_q_unused, sclk_qd_unused;
    logic mosi_s, mosi_q_unused, mosi_r_unused, mosi_f_unused;
    logic ss_s, ss_qd_unused, ss_r_unused, ss_f_unused;

    sync_edge_det #(.DEPTH(2), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d(SCLK),
        .q(sclk_q_unused), .q_d(sclk_qd_unused),
        .rise(sclk_rise), .fall(sclk_fall)
    );

    // MOSI taken from the history flop: one cycle behind edge detect
    sync_edge_det #(.DEPTH(2), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .d(MOSI),
        .q(mosi_q_unused), .q_d(mosi_s),
        .rise(mosi_r_unused), .fall(mosi_f_unused)
    );

    sync_edge_det #(.DEPTH(2), .RST_VAL(1'b1)) u_ss (
        .clk(clk), .rst_n(rst_n), .d(SS_n),
        .q(ss_s), .q_d(ss_qd_unused),
        .rise(ss_r_unused), .fall(ss_f_unused)
    );

    state_t              state;
    logic                strb;
    logic                edg_sh, lsb_sh;
    logic [LEN_W-1:0]    el_sh, bit_cnt;
    logic [WCNT_W-1:0]   ws_sh, word_cnt;
    logic [DATA_W-1:0]   mask_sh, match_sh, lm_sh, shreg;

    logic [6:0]          el_in;
    logic [DATA_W-1:0]   lm_in, sh_nxt;
    logic [LEN_W-1:0]    cnt_nxt;
    logic                done, hit, qual;

    always_comb begin
        el_in = eff_len(7'(len), DW7);
        lm_in = DATA_W'(len_mask(el_in));
        cnt_nxt = bit_cnt + LEN_W'(1);
        done = (cnt_nxt == el_sh);
        if (lsb_sh)
            sh_nxt = shreg | ({{(DATA_W-1){1'b0}}, mosi_s} << bit_cnt);
        else
            sh_nxt = {shreg[DATA_W-2:0], mosi_s};
        hit = (((sh_nxt ^ match_sh) & ~mask_sh & lm_sh) == '0);
        // saturated count never qualifies a later word
        qual = (ws_sh == '0) ||
               (word_cnt != '1 && ws_sh == word_cnt + WCNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            strb      <= 1'b0;
            edg_sh    <= 1'b0;
            lsb_sh    <= 1'b0;
            el_sh     <= '0;
            ws_sh     <= '0;
            mask_sh   <= '0;
            match_sh  <= '0;
            lm_sh     <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_vld    <= 1'b0;
            SPItrig   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_vld    <= 1'b0;
            SPItrig   <= 1'b0;
            frame_err <= 1'b0;
            strb <= (state == RX) && !ss_s &&
                    (edg_sh ? sclk_rise : sclk_fall);
            unique case (state)
                IDLE: begin
                    if (!ss_s) begin
                        edg_sh   <= edg;
                        lsb_sh   <= lsb_first;
                        el_sh    <= LEN_W'(el_in);
                        lm_sh    <= lm_in;
                        ws_sh    <= word_sel;
                        mask_sh  <= mask;
                        match_sh <= match;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                        shreg    <= '0;
                        state    <= RX;
                    end
                end
                RX: begin
                    if (strb) begin
                        if (done) begin
                            rx_data <= sh_nxt & lm_sh;
                            rx_vld  <= 1'b1;
                            SPItrig <= hit && qual;
                            bit_cnt <= '0;
                            shreg   <= '0;
                            if (word_cnt != '1)
                                word_cnt <= word_cnt + WCNT_W'(1);
                        end else begin
                            shreg   <= sh_nxt;
                            bit_cnt <= cnt_nxt;
                        end
                    end
                    // a completing shift wins over the frame end
                    if (ss_s) begin
                        state     <= IDLE;
                        frame_err <= strb ? !done : (bit_cnt != '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rx_trig_gen.sv
// Directed bench for spi_rx_trig_gen with pulse-counting monitor.
// Expected values are hand-computed per test frame.
module tb_spi_rx_trig_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic        edg = 1'b1;
    logic [5:0]  len = 6'd8;
    logic        lsb_first = 1'b0;
    logic [3:0]  word_sel = 4'd0;
    logic [31:0] mask = '0;
    logic [31:0] match = '0;
    logic [31:0] rx_data;
    logic        rx_vld, SPItrig, frame_err;

    int n_tot = 0;
    int n_bad = 0;

    int n_vld = 0, n_trig = 0, n_ferr = 0, n_orph = 0;
    logic [31:0] last_data = '0;
    logic [15:0] trig_hist = '0;

    int s_vld, s_trig, s_ferr, s_orph;

    always #5 clk = ~clk;

    spi_rx_trig_gen #(.DATA_W(32), .LEN_W(6), .WCNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .edg(edg), .len(len), .lsb_first(lsb_first),
        .word_sel(word_sel), .mask(mask), .match(match),
        .rx_data(rx_data), .rx_vld(rx_vld),
        .SPItrig(SPItrig), .frame_err(frame_err)
    );

    always @(negedge clk) begin
        if (rx_vld) begin
            n_vld++;
            last_data = rx_data;
            trig_hist = {trig_hist[14:0], SPItrig};
        end
        if (SPItrig) n_trig++;
        if (SPItrig && !rx_vld) n_orph++;
        if (frame_err) n_ferr++;
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        s_vld = n_vld; s_trig = n_trig;
        s_ferr = n_ferr; s_orph = n_orph;
    endtask

    task automatic send_bit(input logic b);
        MOSI = b;
        #40 SCLK = edg;
        #40 SCLK = ~edg;
    endtask

    task automatic send_word(input logic [31:0] w, input int n,
                             input logic lsb);
        for (int i = 0; i < n; i++)
            send_bit(lsb ? w[i] : w[n-1-i]);
    endtask

    task automatic ss_lo();
        SCLK = ~edg;
        #100 SS_n = 1'b0;
        #100;
    endtask

    task automatic ss_hi();
        #200 SS_n = 1'b1;
        #300;
    endtask

    task automatic expect_d(input string tag, input int v,
                            input int t, input int f);
        chk({tag, "_vld"}, 64'(n_vld - s_vld), 64'(v));
        chk({tag, "_trig"}, 64'(n_trig - s_trig), 64'(t));
        chk({tag, "_ferr"}, 64'(n_ferr - s_ferr), 64'(f));
        chk({tag, "_orph"}, 64'(n_orph - s_orph), 64'd0);
    endtask

    initial begin
        #33;
        chk("rst_data", 64'(rx_data), 64'd0);
        chk("rst_vld", 64'(rx_vld), 64'd0);
        chk("rst_trig", 64'(SPItrig), 64'd0);
        chk("rst_ferr", 64'(frame_err), 64'd0);
        rst_n = 1'b1;
        #50;

        // 1: len 8 MSB-first, rising edge
        edg = 1'b1; len = 6'd8; lsb_first = 1'b0;
        match = 32'hA5; mask = '0; word_sel = 4'd0;
        snap(); ss_lo(); send_word(32'hA5, 8, 1'b0); ss_hi();
        expect_d("t1", 1, 1, 0);
        chk("t1_data", 64'(last_data), 64'h0000_00A5);

        // 2: len 16 LSB-first, exact/masked/miss
        len = 6'd16; lsb_first = 1'b1; match = 32'h1234;
        snap(); ss_lo(); send_word(32'h1234, 16, 1'b1); ss_hi();
        expect_d("t2a", 1, 1, 0);
        chk("t2a_data", 64'(last_data), 64'h1234);
        mask = 32'h000F; match = 32'h123F;
        snap(); ss_lo(); send_word(32'h1234, 16, 1'b1); ss_hi();
        expect_d("t2b", 1, 1, 0);
        mask = '0; match = 32'h1334;
        snap(); ss_lo(); send_word(32'h1234, 16, 1'b1); ss_hi();
        expect_d("t2c", 1, 0, 0);

        // 3: word_sel = 2, three matching bytes
        len = 6'd8; lsb_first = 1'b0; word_sel = 4'd2;
        match = 32'h55;
        snap(); ss_lo();
        for (int k = 0; k < 3; k++) send_word(32'h55, 8, 1'b0);
        ss_hi();
        expect_d("t3", 3, 1, 0);
        chk("t3_which", 64'(trig_hist[2:0]), 64'b010);

        // 4: 12 bits then SS_n high -> partial nibble
        word_sel = 4'd0; match = 32'h3C;
        snap(); ss_lo();
        send_word(32'h3C, 8, 1'b0); send_word(32'hA, 4, 1'b0);
        ss_hi();
        expect_d("t4", 1, 1, 1);
        chk("t4_data", 64'(last_data), 64'h3C);

        // 5: len 0 -> 32 bits, falling edge, len change mid-frame
        edg = 1'b0; len = 6'd0; match = 32'hDEADBEEF;
        snap(); ss_lo();
        send_word(32'hD, 4, 1'b0);
        len = 6'd8;
        send_word(32'hEADBEEF, 28, 1'b0);
        ss_hi();
        expect_d("t5", 1, 1, 0);
        chk("t5_data", 64'(last_data), 64'hDEADBEEF);

        // 7: len beyond DATA_W also means full width
        edg = 1'b1; len = 6'd40; match = 32'h0F0F00FF;
        snap(); ss_lo(); send_word(32'h0F0F00FF, 32, 1'b0); ss_hi();
        expect_d("t7", 1, 1, 0);
        chk("t7_data", 64'(last_data), 64'h0F0F00FF);

        // 6: reset at bit 5, then a clean frame
        len = 6'd8; match = 32'hA5;
        snap(); ss_lo(); send_word(32'h14, 5, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_rdata", 64'(rx_data), 64'd0);
        chk("t6_rvld", 64'(rx_vld), 64'd0);
        chk("t6_rtrig", 64'(SPItrig), 64'd0);
        SS_n = 1'b1; SCLK = 1'b0;
        #100 rst_n = 1'b1;
        #100;
        expect_d("t6r", 0, 0, 0);
        snap(); ss_lo(); send_word(32'hA5, 8, 1'b0); ss_hi();
        expect_d("t6", 1, 1, 0);
        chk("t6_data", 64'(last_data), 64'hA5);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
